// File: rtl/ecc_arb_pkg.sv
// Shared definitions for the three-channel ECC arbiter: state encoding,
// channel count and index width, and a modulo-3 channel increment.
package ecc_arb_pkg;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // (a + b) mod NUM_CH; a may be up to 3 and b up to 2, so one fold suffices
    function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
        logic [CH_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (CH_W+1)'(NUM_CH)) s = s - (CH_W+1)'(NUM_CH);
        return s[CH_W-1:0];
    endfunction

endpackage

// File: rtl/ecc_arb3_rr_pick3.sv
// Combinational round-robin picker: first requester found scanning
// ptr, ptr+1, ptr+2 (mod 3). Returns a one-hot winner and its index.
module rr_pick3
    import ecc_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] winner,
    output logic [CH_W-1:0]   index
);

    logic [CH_W-1:0] cand;
    logic            found;

    // Scan from the pointer and keep the first set request bit
    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = ch_add(ptr, CH_W'(off));
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/ecc_arb3.sv
// Round-robin arbiter/sequencer sharing one error-correction unit among
// three residue-channel detectors.
// Optional feature macro: ECC_ARB_TIMEOUT_EN (BUSY timeout, sticky flag).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | unit free, grant = 0, waiting for any request
// ST_BUSY    | grant held, waiting for corr_done (or timeout expiry)
// ST_RELEASE | one-cycle gap after ack so the requester can drop req
module ecc_arb3
    import ecc_arb_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TMO_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              corr_done,
    input  logic              corr_fail,
    output logic              any_req,
    output logic [NUM_CH-1:0] grant,
    output logic              corr_start,
    output logic [CH_W-1:0]   corr_sel,
    output logic [NUM_CH-1:0] ack,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              timeout
);

    arb_state_t        state;
    logic [CH_W-1:0]   ptr;
    logic [NUM_CH-1:0] pick_win;
    logic [CH_W-1:0]   pick_idx;
    logic              tmo_hit;
    logic              finish;
    logic              fin_fail;

    rr_pick3 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_win),
        .index  (pick_idx)
    );

`ifdef ECC_ARB_TIMEOUT_EN
    // Expiry fires on the BUSY cycle whose increment would reach all-ones
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

    logic [TMO_W-1:0] tmo_cnt;

    // A real corr_done in the expiry cycle takes precedence over the timeout
    assign tmo_hit = (state == ST_BUSY) && !corr_done && (tmo_cnt == TMO_LAST);

    // Count BUSY cycles without completion; idle clears it ahead of each grant
    always_ff @(posedge clk) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == ST_IDLE)
            tmo_cnt <= '0;
        else if (state == ST_BUSY && !corr_done)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            timeout <= 1'b0;
        else if (tmo_hit)
            timeout <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    assign finish   = (state == ST_BUSY) && (corr_done || tmo_hit);
    assign fin_fail = corr_done ? corr_fail : 1'b1;

    // Registered any-request flag for the stall logic, independent of the FSM
    always_ff @(posedge clk) begin
        if (reset)
            any_req <= 1'b0;
        else
            any_req <= |req;
    end

    // Arbitration/sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            corr_sel   <= '0;
            corr_start <= 1'b0;
            ack        <= '0;
            fail_cnt   <= '0;
            ptr        <= '0;
        end else begin
            corr_start <= 1'b0;
            ack        <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state      <= ST_BUSY;
                        grant      <= pick_win;
                        corr_sel   <= pick_idx;
                        corr_start <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        state <= ST_RELEASE;
                        ack   <= grant;
                        grant <= '0;
                        ptr   <= ch_add(corr_sel, CH_W'(1));
                        if (fin_fail && (fail_cnt != '1))
                            fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_arb3.sv
// Self-checking bench for ecc_arb3 (CNT_W=2, TMO_W=3). A cycle-level
// behavioural model predicts every output after each clock edge; directed
// steps add constant expectations for the key scenarios, then random traffic.
module tb_ecc_arb3;

    localparam int CNT_W = 2;
    localparam int TMO_W = 3;
`ifdef ECC_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req;
    logic             corr_done;
    logic             corr_fail;
    logic             any_req;
    logic [2:0]       grant;
    logic             corr_start;
    logic [1:0]       corr_sel;
    logic [2:0]       ack;
    logic [CNT_W-1:0] fail_cnt;
    logic             timeout;

    always #5 clk = ~clk;

    ecc_arb3 #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .corr_done  (corr_done),
        .corr_fail  (corr_fail),
        .any_req    (any_req),
        .grant      (grant),
        .corr_start (corr_start),
        .corr_sel   (corr_sel),
        .ack        (ack),
        .fail_cnt   (fail_cnt),
        .timeout    (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state: owner channel (-1 = free), release gap, pointer, counters
    int   m_owner = -1;
    bit   m_gap   = 1'b0;
    int   m_ptr   = 0;
    int   m_fail  = 0;
    int   m_busy  = 0;
    bit   m_tmo   = 1'b0;
    logic e_any   = 1'b0;
    logic e_start = 1'b0;
    logic [2:0] e_ack = '0;

    int   n_wait;
    bit   got_ack;
    logic [2:0] fair_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int   fail_exp [5] = '{1, 2, 3, 3, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge of the reference behaviour, using the inputs seen at that edge
    task automatic model_step();
        bit fin;
        bit fl;
        e_start = 1'b0;
        e_ack   = '0;
        if (reset) begin
            m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_fail = 0;
            m_busy = 0; m_tmo = 1'b0; e_any = 1'b0;
            return;
        end
        e_any = |req;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 3; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 3]) begin
                    m_owner = (m_ptr + k) % 3;
                    e_start = 1'b1;
                    m_busy  = 0;
                end
            end
        end else begin
            m_busy++;
            fin = corr_done || (TMO_EN && m_busy == (1 << TMO_W) - 1);
            if (fin) begin
                fl = corr_done ? corr_fail : 1'b1;
                if (!corr_done) m_tmo = 1'b1;
                e_ack   = 3'(1 << m_owner);
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
                m_gap   = 1'b1;
                if (fl && m_fail < (1 << CNT_W) - 1) m_fail++;
            end
        end
    endtask

    task automatic check_all();
        chk("any_req", any_req, e_any);
        chk("grant", grant, (m_owner < 0) ? 3'b000 : 3'(1 << m_owner));
        chk("corr_start", corr_start, e_start);
        chk("ack", ack, e_ack);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("timeout", timeout, m_tmo);
        if (grant != 3'b000) chk("corr_sel", corr_sel, m_owner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // full transaction from IDLE: grant, lat BUSY cycles, ack, release, idle
    task automatic run_txn(input logic [2:0] r, input int lat, input logic fl);
        req = r;
        tick();
        repeat (lat - 1) tick();
        corr_done = 1'b1;
        corr_fail = fl;
        tick();
        corr_done = 1'b0;
        corr_fail = 1'b0;
        req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; req = '0; corr_done = 1'b0; corr_fail = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_grant", grant, 3'b000);
        chk("rst_sel", corr_sel, 2'd0);
        chk("rst_any", any_req, 1'b0);
        chk("rst_fail", fail_cnt, 0);
        reset = 1'b0;

        // single request on channel 1
        req = 3'b010;
        tick();
        chk("single_any", any_req, 1'b1);
        chk("single_grant", grant, 3'b010);
        chk("single_sel", corr_sel, 2'd1);
        chk("single_start", corr_start, 1'b1);
        tick();
        chk("single_start_end", corr_start, 1'b0);
        tick();
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        chk("single_ack", ack, 3'b010);
        chk("single_free", grant, 3'b000);
        req = 3'b000;
        tick();
        chk("single_ack_end", ack, 3'b000);

        // stray done while idle
        corr_done = 1'b1; corr_fail = 1'b1;
        tick();
        chk("stray_idle_ack", ack, 3'b000);
        chk("stray_idle_fail", fail_cnt, 0);
        corr_done = 1'b0; corr_fail = 1'b0;

        // next search starts at channel 2, so 011 resolves to channel 0
        req = 3'b011;
        tick();
        chk("ptr_from_2", grant, 3'b001);
        tick();
        corr_done = 1'b1;
        tick();
        chk("wrap_ack", ack, 3'b001);
        // stray done during the release gap
        corr_fail = 1'b1; req = 3'b000;
        tick();
        chk("stray_rel_ack", ack, 3'b000);
        chk("stray_rel_fail", fail_cnt, 0);
        corr_done = 1'b0; corr_fail = 1'b0;
        tick();

        // reset two cycles into a grant
        req = 3'b001;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rstbusy_grant", grant, 3'b000);
        chk("rstbusy_ack", ack, 3'b000);
        chk("rstbusy_start", corr_start, 1'b0);
        chk("rstbusy_sel", corr_sel, 2'd0);
        reset = 1'b0;

        // fairness with all three requesting; pointer restarts at 0 after reset
        req = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("fair_grant", grant, fair_exp[i]);
            tick();
            corr_done = 1'b1;
            tick();
            corr_done = 1'b0;
            chk("fair_ack", ack, fair_exp[i]);
            req = req & ~fair_exp[i];
            tick();
            chk("fair_gap", grant, 3'b000);
            req = 3'b111;
            tick();
        end
        tick();
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        req = 3'b000;
        tick();
        tick();

        // saturating failure count
        for (int i = 0; i < 5; i++) begin
            run_txn(3'b100, 1 + i, 1'b1);
            chk("fail_sat", fail_cnt, fail_exp[i]);
        end

        // timeout behaviour
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 3'b100;
        tick();
`ifdef ECC_ARB_TIMEOUT_EN
        n_wait = 0;
        got_ack = 1'b0;
        while (n_wait < 20 && !got_ack) begin
            tick();
            n_wait++;
            if (ack != 3'b000) got_ack = 1'b1;
        end
        chk("tmo_busy_cycles", n_wait, 7);
        chk("tmo_ack", ack, 3'b100);
        chk("tmo_fail", fail_cnt, 1);
        chk("tmo_flag", timeout, 1'b1);
        req = 3'b000;
        tick();
        tick();
        run_txn(3'b100, 7, 1'b0);
        chk("tmo_tie_fail", fail_cnt, 1);
        chk("tmo_sticky", timeout, 1'b1);
`else
        repeat (12) tick();
        chk("notmo_grant", grant, 3'b100);
        chk("notmo_flag", timeout, 1'b0);
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        chk("notmo_ack", ack, 3'b100);
        req = 3'b000;
        tick();
        tick();
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req       = 3'($urandom_range(0, 7));
            corr_done = ($urandom_range(0, 3) == 0);
            corr_fail = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0; req = '0; corr_done = 1'b0; corr_fail = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_arb3.md
# ecc_arb3

Round-robin arbiter and sequencer that shares one error-correction unit among three residue-channel error detectors in the error-correcting TPU datapath. Each detector raises a level request when its channel flags a residue inconsistency. The block grants the correction unit to one channel at a time, starts the correction, and waits for completion. It then acknowledges the requester and keeps a saturating failure count. A registered any-request flag is also exported to the pipeline stall logic.

## Interface
- CNT_W, 8: width of the failure counter.
- TMO_W, 6: width of the timeout counter. The timeout limit is 2^TMO_W−1 cycles.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  3  per-channel correction request; level, held until matching ack
- corr_done  in  1  correction unit completion pulse
- corr_fail  in  1  correction result invalid; qualified by corr_done
- any_req  out  1  registered OR of req[2:0]
- grant  out  3  one-hot owner of correction unit; all-zero when free
- corr_start  out  1  one-cycle start pulse to correction unit
- corr_sel  out  2  selected channel index 0..2, valid while grant≠0
- ack  out  3  one-cycle completion pulse to the owning requester
- fail_cnt  out  CNT_W  saturating count of failed or timed-out corrections
- timeout  out  1  sticky; set on a correction timeout

## Operation
- States:
  - IDLE: grant is all-zero.
  - BUSY: a grant is held and the block is waiting for corr_done.
  - RELEASE: a one-cycle gap that ignores req, so the requester can drop it after ack.
- IDLE → BUSY:
  - Condition: req≠0 at an edge.
  - Winner: the first set bit found by searching from the rotating pointer ptr, in order ptr, ptr+1, ptr+2 (mod 3).
  - Actions: register grant and corr_sel, pulse corr_start, clear the timeout counter.
- BUSY → RELEASE:
  - Condition: corr_done=1.
  - Actions: pulse ack[corr_sel], clear grant, set ptr = (corr_sel+1) mod 3.
  - If corr_fail=1, increment fail_cnt. It saturates at all-ones.
- RELEASE → IDLE unconditionally.
- If a requester drops req while granted, the grant is still held until completion. The block never aborts on req deassertion.
- corr_done or corr_fail while in IDLE or RELEASE is ignored.
- any_req = req[0]|req[1]|req[2], registered, independent of the state machine.

## Timing
- Reset values: any_req=0, grant=0, corr_start=0, corr_sel=0, ack=0, fail_cnt=0, timeout=0, state=IDLE, ptr=0, timeout counter=0.
- A reset in any state, including mid-correction, returns to these values on the next edge. No ack is issued for the aborted grant.
- any_req lags req by 1 cycle.
- Request sampled at edge k (state IDLE): grant, corr_sel and corr_start are valid after edge k. corr_start is high for that cycle only.
- corr_done sampled at edge m: ack is high and grant is 0 after edge m. State is RELEASE after edge m and IDLE after edge m+1. The earliest next grant is after edge m+2.
- corr_done may arrive in the first BUSY cycle. The minimum occupancy is 1 cycle.

## Configuration
- ECC_ARB_TIMEOUT_EN defined:
  - The timeout counter increments on every BUSY cycle without corr_done.
  - When the count reaches 2^TMO_W−1, the block behaves as if corr_done=1 and corr_fail=1 arrived: ack, fail_cnt increment, RELEASE. It also sets timeout.
  - If the real corr_done coincides with expiry, corr_done wins. The outcome is taken from corr_fail and timeout is not set.
- ECC_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely. timeout is tied to 0 and the timeout counter is not built.

## Structure
- Package ecc_arb_pkg holds:
  - the state encoding (IDLE, BUSY, RELEASE);
  - constant NUM_CH=3;
  - the channel index width (2).
- Sub-module rr_pick3 is purely combinational. Inputs: req[2:0] and ptr[1:0]. Outputs: one-hot winner and its index.

## Test plan
- Reset mid-BUSY: req=001, reset asserted 2 cycles after grant → all outputs 0 next cycle, ptr=0, no ack.
- Single request: req=010 → any_req=1 one cycle later; grant=010, corr_sel=1, one corr_start pulse. corr_done → ack=010 for one cycle; next winner searched from channel 2.
- Fairness: req=111 held, with each requester dropping and reasserting its req after its ack → grants 001, 010, 100, 001 in order, with a 2-cycle gap after each ack.
- Failure counting: CNT_W=2, five completions with corr_fail=1 → fail_cnt goes 1, 2, 3, 3, 3.
- Timeout (macro on, TMO_W=3): grant, no corr_done → ack on the 7th BUSY cycle, fail_cnt+1, timeout=1 (sticky). Repeat with corr_done in the expiry cycle and corr_fail=0 → no increment, timeout unchanged.
- Stray done: corr_done pulses while in IDLE and RELEASE → no ack, no fail_cnt change.
